// File: rtl/ll_rd_arbiter_if.sv
// Bus bundle between the link-list read arbiter, its requesters (PktRead
// next-address ports and the drop channel) and the link-list SRAM read port.
// The master modport is the arbiter side; the slave modport is the
// requester/SRAM side.
interface ll_rd_arbiter_if #(
  parameter int ADDR_LENTH = 12
);
  logic [4-1:0]            req;
  logic [4*ADDR_LENTH-1:0] addr;
  logic                    drop_req;
  logic [ADDR_LENTH-1:0]   drop_addr;
  logic                    hold;
  logic [4-1:0]            gnt;
  logic                    drop_gnt;
  logic                    sram_ren;
  logic [ADDR_LENTH-1:0]   sram_raddr;
  logic [ADDR_LENTH-1:0]   sram_rdata;
  logic [ADDR_LENTH-1:0]   ldata;
  logic [4-1:0]            ldata_vld;
  logic [ADDR_LENTH-1:0]   drop_data;
  logic                    drop_data_vld;

  modport master (
    input  req, addr, drop_req, drop_addr, hold, sram_rdata,
    output gnt, drop_gnt, sram_ren, sram_raddr,
           ldata, ldata_vld, drop_data, drop_data_vld
  );

  modport slave (
    output req, addr, drop_req, drop_addr, hold, sram_rdata,
    input  gnt, drop_gnt, sram_ren, sram_raddr,
           ldata, ldata_vld, drop_data, drop_data_vld
  );
endinterface

// File: rtl/ll_rd_arbiter.sv
// Link-list SRAM read-port arbiter: drop channel first, round-robin among the
// four PktRead next-address ports, 1-cycle tagged data return.
// Optional feature macro: LL_ARB_STARVE_GUARD_EN (bounds consecutive drop
// grants to MAX_DROP_BURST while a port waits).

// Per-port lock: a port is blocked from the grant until its data returned.
module ll_rd_arb_lane (
  input  logic iClk,
  input  logic iRst_n,
  input  logic req,
  input  logic gnt,
  input  logic vld,
  output logic elig
);
  logic lock;

  // set on grant, released after the data-valid cycle
  always_ff @(posedge iClk or negedge iRst_n)
    if (!iRst_n)  lock <= 1'b0;
    else if (gnt) lock <= 1'b1;
    else if (vld) lock <= 1'b0;

  assign elig = req & ~lock;
endmodule

module ll_rd_arbiter #(
  parameter int ADDR_LENTH     = 12,
  parameter int MAX_DROP_BURST = 4
) (
  input logic             iClk,
  input logic             iRst_n,
  ll_rd_arbiter_if.master bus
);
  localparam int NP     = 4;
  localparam int STAGES = 1;

  logic [NP-1:0]         elig, gnt, ldata_vld;
  logic [1:0]            ptr, win, tag_port;
  logic                  found, drop_win, port_win, port_first, tag_drop;
  logic [STAGES:1]       vld_pipe;
  logic [ADDR_LENTH-1:0] ldata, drop_data;
  logic                  drop_data_vld;

  if (MAX_DROP_BURST < 1) begin : g_bad_burst
    $error("MAX_DROP_BURST must be at least 1");
  end

  for (genvar i = 0; i < NP; i++) begin : g_lane
    ll_rd_arb_lane u_lane (
      .iClk  (iClk),
      .iRst_n(iRst_n),
      .req   (bus.req[i]),
      .gnt   (gnt[i]),
      .vld   (ldata_vld[i]),
      .elig  (elig[i])
    );
  end

  // round-robin search over eligible ports starting at the pointer
  always_comb begin
    found = 1'b0;
    win   = ptr;
    for (int k = 0; k < NP; k++) begin
      if (!found && elig[ptr + 2'(k)]) begin
        found = 1'b1;
        win   = ptr + 2'(k);
      end
    end
  end

`ifdef LL_ARB_STARVE_GUARD_EN
  localparam int CW = $clog2(MAX_DROP_BURST + 1);
  logic [CW-1:0] burst;

  assign port_first = found && (burst >= CW'(MAX_DROP_BURST));

  // count drop grants taken while some port was waiting
  always_ff @(posedge iClk or negedge iRst_n)
    if (!iRst_n)                burst <= '0;
    else if (!found || port_win) burst <= '0;
    else if (drop_win)          burst <= burst + CW'(1);
`else
  assign port_first = 1'b0;
`endif

  // single grant per cycle: drop first unless the guard forces a port turn
  always_comb begin
    drop_win = iRst_n && !bus.hold && bus.drop_req && !port_first;
    port_win = iRst_n && !bus.hold && found && !drop_win;
    gnt      = port_win ? (NP'(1) << win) : '0;
  end

  assign bus.gnt        = gnt;
  assign bus.drop_gnt   = drop_win;
  assign bus.sram_ren   = drop_win | port_win;
  assign bus.sram_raddr = drop_win ? bus.drop_addr :
                          port_win ? bus.addr[int'(win)*ADDR_LENTH +: ADDR_LENTH] :
                                     '0;

  // pointer advances past the winner on port grants only
  always_ff @(posedge iClk or negedge iRst_n)
    if (!iRst_n)       ptr <= '0;
    else if (port_win) ptr <= win + 2'd1;

  // tag the issued read so the returning data can be steered
  always_ff @(posedge iClk or negedge iRst_n)
    if (!iRst_n) begin
      vld_pipe <= '0;
      tag_drop <= 1'b0;
      tag_port <= '0;
    end else begin
      vld_pipe[1] <= drop_win | port_win;
      tag_drop    <= drop_win;
      tag_port    <= win;
    end

  // steer read data to the tagged requester; everything else reads zero
  always_comb begin
    ldata         = '0;
    ldata_vld     = '0;
    drop_data     = '0;
    drop_data_vld = 1'b0;
    if (vld_pipe[STAGES]) begin
      if (tag_drop) begin
        drop_data     = bus.sram_rdata;
        drop_data_vld = 1'b1;
      end else begin
        ldata               = bus.sram_rdata;
        ldata_vld[tag_port] = 1'b1;
      end
    end
  end

  assign bus.ldata         = ldata;
  assign bus.ldata_vld     = ldata_vld;
  assign bus.drop_data     = drop_data;
  assign bus.drop_data_vld = drop_data_vld;
endmodule

// File: tb/tb_ll_rd_arbiter.sv
// Bench for ll_rd_arbiter: per-cycle grant vectors from a table, a scoreboard
// for the 1-cycle read return, and a hand sequence for drop starvation.
module tb_ll_rd_arbiter;
  localparam int AW = 12;
`ifdef LL_ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif
  localparam logic [AW-1:0] DROP_ADDR = 12'h7A0;
  localparam logic [AW-1:0] SRAM_OFS  = 12'h333;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ll_rd_arbiter_if #(.ADDR_LENTH(AW)) bus ();

  ll_rd_arbiter #(.ADDR_LENTH(AW), .MAX_DROP_BURST(4)) dut (
    .iClk  (clk),
    .iRst_n(rst_n),
    .bus   (bus.master)
  );

  // SRAM model: contents are address + 0x333, 1-cycle read latency
  always @(posedge clk)
    if (bus.sram_ren) bus.sram_rdata <= bus.sram_raddr + SRAM_OFS;

  logic [AW-1:0] port_addr [4];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic       drop;
    logic       hold;
    logic [3:0] gnt;
    logic       dgnt;
  } vec_t;
  vec_t vt[$];

  task automatic add(input logic r, input logic [3:0] rq, input logic d, input logic h,
                     input logic [3:0] g, input logic dg);
    vec_t v;
    v.rst = r; v.req = rq; v.drop = d; v.hold = h; v.gnt = g; v.dgnt = dg;
    vt.push_back(v);
  endtask

  // scoreboard of reads expected back one cycle after each grant
  typedef struct {
    logic          drop;
    logic [3:0]    vld;
    logic [AW-1:0] data;
  } exp_t;
  exp_t q[$];
  logic mon_en = 1'b1;

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (!rst_n) begin
          q.delete();
          chk("rst_ctrl", {21'd0, bus.sram_ren, bus.gnt, bus.drop_gnt, bus.ldata_vld, bus.drop_data_vld}, 32'd0);
          chk("rst_data", {8'd0, bus.ldata, bus.drop_data}, 32'd0);
        end else begin
          if (q.size() > 0) begin
            e = q.pop_front();
            chk("ldata_vld", {28'd0, bus.ldata_vld}, {28'd0, e.vld});
            chk("drop_vld", {31'd0, bus.drop_data_vld}, {31'd0, e.drop});
            chk("ldata", {20'd0, bus.ldata}, e.drop ? 32'd0 : {20'd0, e.data});
            chk("drop_data", {20'd0, bus.drop_data}, e.drop ? {20'd0, e.data} : 32'd0);
          end else begin
            chk("idle_vld", {27'd0, bus.ldata_vld, bus.drop_data_vld}, 32'd0);
            chk("idle_data", {8'd0, bus.ldata, bus.drop_data}, 32'd0);
          end
          chk("ren", {31'd0, bus.sram_ren}, {31'd0, (|bus.gnt) | bus.drop_gnt});
          if (bus.drop_gnt) begin
            chk("gnt_excl", {28'd0, bus.gnt}, 32'd0);
            chk("raddr_drop", {20'd0, bus.sram_raddr}, {20'd0, DROP_ADDR});
            e.drop = 1'b1; e.vld = 4'd0; e.data = DROP_ADDR + SRAM_OFS;
            q.push_back(e);
          end else if (|bus.gnt) begin
            chk("gnt_onehot", $countones(bus.gnt), 32'd1);
            for (int p = 0; p < 4; p++)
              if (bus.gnt[p]) begin
                chk("raddr_port", {20'd0, bus.sram_raddr}, {20'd0, port_addr[p]});
                e.drop = 1'b0; e.vld = bus.gnt; e.data = port_addr[p] + SRAM_OFS;
              end
            q.push_back(e);
          end
        end
      end
    end
  end

  initial begin
    for (int p = 0; p < 4; p++) port_addr[p] = 12'h122 + AW'(p);
    for (int p = 0; p < 4; p++) bus.addr[p*AW +: AW] = port_addr[p];
    bus.drop_addr = DROP_ADDR;
    bus.req = '0; bus.drop_req = 1'b0; bus.hold = 1'b0;

    //  rst  req     drop  hold  gnt     dgnt
    add(1, 4'b0000, 0, 0, 4'b0000, 0);   // reset
    add(0, 4'b0010, 0, 0, 4'b0010, 0);   // single: port1 @0x123 -> 0x456
    add(0, 4'b0000, 0, 0, 4'b0000, 0);
    add(1, 4'b0000, 0, 0, 4'b0000, 0);
    add(0, 4'b1111, 0, 0, 4'b0001, 0);   // fairness 0,1,2,3,0
    add(0, 4'b1111, 0, 0, 4'b0010, 0);
    add(0, 4'b1111, 0, 0, 4'b0100, 0);
    add(0, 4'b1111, 0, 0, 4'b1000, 0);
    add(0, 4'b1111, 0, 0, 4'b0001, 0);
    add(0, 4'b0000, 0, 0, 4'b0000, 0);
    add(1, 4'b0000, 0, 0, 4'b0000, 0);
    add(0, 4'b0001, 1, 0, 4'b0000, 1);   // drop beats port0
    add(0, 4'b0001, 0, 0, 4'b0001, 0);
    add(0, 4'b0000, 0, 0, 4'b0000, 0);
    add(1, 4'b0000, 0, 0, 4'b0000, 0);
    add(0, 4'b1111, 0, 0, 4'b0001, 0);   // hold: cycle-2 read still returns
    add(0, 4'b1111, 0, 0, 4'b0010, 0);
    add(0, 4'b1111, 0, 1, 4'b0000, 0);
    add(0, 4'b1111, 0, 1, 4'b0000, 0);
    add(0, 4'b1111, 0, 1, 4'b0000, 0);
    add(0, 4'b1111, 0, 0, 4'b0100, 0);   // resumes at saved pointer
    add(0, 4'b1111, 0, 0, 4'b1000, 0);
    add(0, 4'b1111, 0, 0, 4'b0001, 0);
    add(0, 4'b0010, 0, 0, 4'b0010, 0);   // grant then reset: tag dropped
    add(1, 4'b0000, 0, 0, 4'b0000, 0);
    add(0, 4'b0000, 0, 0, 4'b0000, 0);
    add(0, 4'b1111, 1, 0, 4'b0000, 1);   // drop + all ports
    add(0, 4'b1111, 0, 0, 4'b0001, 0);
    add(0, 4'b0000, 0, 0, 4'b0000, 0);

    for (int i = 0; i < vt.size(); i++) begin
      @(posedge clk); #1;
      rst_n        = !vt[i].rst;
      bus.req      = vt[i].req;
      bus.drop_req = vt[i].drop;
      bus.hold     = vt[i].hold;
      @(negedge clk);
      chk($sformatf("gnt[%0d]", i), {28'd0, bus.gnt}, {28'd0, vt[i].gnt});
      chk($sformatf("drop_gnt[%0d]", i), {31'd0, bus.drop_gnt}, {31'd0, vt[i].dgnt});
    end

    // starvation: drop held 10 cycles against port2
    @(posedge clk); #1;
    rst_n = 1'b0; bus.req = '0; bus.drop_req = 1'b0; bus.hold = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      rst_n        = 1'b1;
      bus.drop_req = 1'b1;
      bus.req      = (GUARD && i > 4) ? 4'b0000 : 4'b0100;
      @(negedge clk);
      chk($sformatf("starve_gnt[%0d]", i), {28'd0, bus.gnt},
          (GUARD && i == 4) ? 32'b0100 : 32'd0);
      chk($sformatf("starve_dgnt[%0d]", i), {31'd0, bus.drop_gnt},
          (GUARD && i == 4) ? 32'd0 : 32'd1);
    end
    @(posedge clk); #1;
    bus.drop_req = 1'b0;
    bus.req      = GUARD ? 4'b0000 : 4'b0100;
    @(negedge clk);
    chk("starve_release", {28'd0, bus.gnt}, GUARD ? 32'd0 : 32'b0100);
    @(posedge clk); #1;
    bus.req = '0;
    @(negedge clk);
    @(posedge clk); #1;
    mon_en = 1'b0;
    chk("sb_drained", q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
